text_pixel_generator: RTL

- Downstream consumer of the 800x600@72 timing generator.
- Converts the text-grid coordinates and load/draw strobes into a per-pixel 4-bit colour index. It does this by fetching a 16-bit cell from text RAM, then the 8-pixel glyph row from font ROM, then shifting the glyph out MSB first.
- Delays hsync/vsync by the same one-cycle latency as the pixel output, applies blink, and overlays a hardware cursor.
- Output feeds the palette/DAC stage.

---
 rtl/text_pixel_generator.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/text_pixel_generator.sv
// Purpose : turns text-grid coordinates and load/draw strobes into a 4-bit colour index per pixel.
// Latency : colour and syncs are 1 cycle after the inputs. Text RAM and font ROM reads each take 1 cycle.
// Backpressure: none; free-running with the timing generator, no stall path.
//
// Ports:
//   clk, reset                   : pixel clock; asynchronous, active-high reset
//   hsync, vsync, drawing        : raw timing from the timing generator
//   clk_load_char/_design/_draw  : per-cell fetch and draw strobes
//   xtext, ytext, ychar          : cell column, cell row and scanline within the cell
//   cursor_x, cursor_y, cursor_en: hardware cursor position and enable
//   text_addr/text_rd/text_data  : synchronous text RAM port
//   font_addr/font_rd/font_data  : synchronous font ROM port
//   hsync_o, vsync_o, color      : outputs to the palette/DAC stage
module text_pixel_generator #(
    parameter int TEXTCOLS   = 100,
    parameter int TEXTROWS   = 60,
    parameter int CHARHEIGHT = 10,
    parameter int TEXT_AW    = 13,
    parameter int BLINK_BIT  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               drawing,
    input  logic               clk_load_char,
    input  logic               clk_load_design,
    input  logic               clk_draw_char,
    input  logic [6:0]         xtext,
    input  logic [5:0]         ytext,
    input  logic [3:0]         ychar,
    input  logic [6:0]         cursor_x,
    input  logic [5:0]         cursor_y,
    input  logic               cursor_en,
    output logic [TEXT_AW-1:0] text_addr,
    output logic               text_rd,
    input  logic [15:0]        text_data,
    output logic [11:0]        font_addr,
    output logic               font_rd,
    input  logic [7:0]         font_data,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [3:0]         color
);

    localparam logic [6:0] COLS_LIM   = 7'(TEXTCOLS);
    localparam logic [5:0] ROWS_LIM   = 6'(TEXTROWS);
    localparam logic [3:0] CURSOR_Y0  = 4'(CHARHEIGHT - 2);

    // fetch side
    logic        load_d1;
    logic        design_d1;
    logic [6:0]  x_lat;
    logic [5:0]  y_lat;
    logic [15:0] cell_q;

    // pending cell: fully fetched, waiting for its draw strobe
    logic [7:0]  glyph_pend;
    logic [3:0]  fg_pend;
    logic [2:0]  bg_pend;
    logic        blink_pend;
    logic        cursor_pend;

    // draw side
    logic [7:0]  shift_q;
    logic [3:0]  fg_q;
    logic [2:0]  bg_q;
    logic        blink_q;
    logic        cursor_q;

    logic [7:0]  frame_cnt;

    logic        cursor_hit;
    logic        pix_bit;
    logic [3:0]  pix_fg;
    logic [2:0]  pix_bg;
    logic        pix_blink;
    logic        pix_cursor;
    logic        phase;
    logic [3:0]  fg_eff;
    logic        pix_on;
    logic [3:0]  color_d;

    // Memory ports are gated by reset so the bus reads idle while reset is held.
    assign text_rd   = clk_load_char & ~reset;
    assign text_addr = text_rd ? (TEXT_AW'(ytext) * TEXT_AW'(TEXTCOLS) + TEXT_AW'(xtext))
                               : '0;
    assign font_rd   = clk_load_design & ~reset;
    assign font_addr = font_rd ? {cell_q[7:0], ychar} : 12'd0;

    // Cursor match uses the coordinates latched with the text fetch, because
    // xtext/ytext have already moved on by the time the glyph comes back.
    // The explicit range check keeps an off-screen cursor from ever matching.
    assign cursor_hit = cursor_en
                      && (x_lat == cursor_x) && (y_lat == cursor_y)
                      && (cursor_x < COLS_LIM) && (cursor_y < ROWS_LIM)
                      && (ychar >= CURSOR_Y0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_d1     <= 1'b0;
            design_d1   <= 1'b0;
            x_lat       <= '0;
            y_lat       <= '0;
            cell_q      <= '0;
            glyph_pend  <= '0;
            fg_pend     <= '0;
            bg_pend     <= '0;
            blink_pend  <= 1'b0;
            cursor_pend <= 1'b0;
        end else begin
            load_d1   <= clk_load_char;
            design_d1 <= clk_load_design;
            if (clk_load_char) begin
                x_lat <= xtext;
                y_lat <= ytext;
            end
            // RAM data is valid in the cycle after the read strobe.
            if (load_d1) begin
                cell_q <= text_data;
            end
            if (design_d1) begin
                glyph_pend  <= font_data;
                fg_pend     <= cell_q[11:8];
                bg_pend     <= cell_q[14:12];
                blink_pend  <= cell_q[15];
                cursor_pend <= cursor_hit;
            end
        end
    end

    // On the draw strobe the first pixel comes straight from the pending
    // registers; the rest of the cell comes out of the shift register.
    always_comb begin
        pix_bit    = shift_q[7];
        pix_fg     = fg_q;
        pix_bg     = bg_q;
        pix_blink  = blink_q;
        pix_cursor = cursor_q;
        if (clk_draw_char) begin
            pix_bit    = glyph_pend[7];
            pix_fg     = fg_pend;
            pix_bg     = bg_pend;
            pix_blink  = blink_pend;
            pix_cursor = cursor_pend;
        end
    end

    assign phase  = frame_cnt[BLINK_BIT];
    assign fg_eff = (pix_blink && phase) ? {1'b0, pix_bg} : pix_fg;
    // The cursor shows only in the "on" half of the blink period.
    assign pix_on = pix_bit | (pix_cursor & ~phase);

    always_comb begin
        color_d = 4'd0;
        if (drawing) begin
            color_d = pix_on ? fg_eff : {1'b0, pix_bg};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            blink_q  <= 1'b0;
            cursor_q <= 1'b0;
        end else if (clk_draw_char) begin
            shift_q  <= {glyph_pend[6:0], 1'b0};
            fg_q     <= fg_pend;
            bg_q     <= bg_pend;
            blink_q  <= blink_pend;
            cursor_q <= cursor_pend;
        end else if (drawing) begin
            shift_q  <= {shift_q[6:0], 1'b0};
        end
    end

    // vsync_o doubles as the previous vsync sample for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color     <= 4'd0;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
            frame_cnt <= '0;
        end else begin
            color   <= color_d;
            hsync_o <= hsync;
            vsync_o <= vsync;
            if (vsync_o && !vsync) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
